// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, start/data/stop sampling FSM and a show-ahead output FIFO.
// Define UART_RX_PARITY_EN to add the PARITY parameter, a parity state and the parity_err pulse.
module uart_rx_fifo #(
  parameter int CLK        = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int BITS       = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY     = 2
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic [BITS-1:0]             m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        frame_err,
  output logic                        overrun,
`ifdef UART_RX_PARITY_EN
  output logic                        parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV  = CLK / BAUD_RATE;
  localparam int HALF = (DIV - 1) / 2;
  localparam int CW   = $clog2(DIV);
  localparam int IW   = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t          state, state_nx;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   clkd, clkd_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [BITS-1:0] shift, shift_nx;
  logic            sc, sc_nx;
  logic            ferr_q, ferr_nx;
  logic            perr_q, perr_nx;
  logic            tick, frame_done, frame_bad, push;
  logic            par_expect;

`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = (PARITY != 0);
  assign par_expect = (PARITY == 1) ? ~^shift : ^shift;
`else
  localparam bit HAS_PAR = 1'b0;
  assign par_expect = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      clkd   <= '0;
      idx    <= '0;
      shift  <= '0;
      sc     <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state  <= state_nx;
      clkd   <= clkd_nx;
      idx    <= idx_nx;
      shift  <= shift_nx;
      sc     <= sc_nx;
      ferr_q <= ferr_nx;
      perr_q <= perr_nx;
    end
  end

  assign tick = (clkd == CW'(DIV - 1));

  always_comb begin
    state_nx   = state;
    clkd_nx    = clkd;
    idx_nx     = idx;
    shift_nx   = shift;
    sc_nx      = sc;
    ferr_nx    = ferr_q;
    perr_nx    = perr_q;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        clkd_nx = '0;
        idx_nx  = '0;
        sc_nx   = 1'b0;
        ferr_nx = 1'b0;
        perr_nx = 1'b0;
        if (!rx_s) state_nx = S_START;
      end
      S_START: begin
        if (clkd == CW'(HALF)) begin
          clkd_nx  = '0;
          state_nx = rx_s ? S_IDLE : S_DATA;
        end else begin
          clkd_nx = clkd + CW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          clkd_nx       = '0;
          shift_nx[idx] = rx_s;
          if (idx == IW'(BITS - 1)) begin
            idx_nx   = '0;
            state_nx = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            idx_nx = idx + IW'(1);
          end
        end else begin
          clkd_nx = clkd + CW'(1);
        end
      end
      S_PARITY: begin
        if (tick) begin
          clkd_nx  = '0;
          perr_nx  = (rx_s != par_expect);
          state_nx = S_STOP;
        end else begin
          clkd_nx = clkd + CW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          clkd_nx = '0;
          if (sc == 1'(STOP_BITS - 1)) begin
            // Leave at mid-stop-bit so a back-to-back start edge is not missed.
            frame_done = 1'b1;
            frame_bad  = ferr_q | ~rx_s;
            state_nx   = rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            sc_nx   = 1'b1;
            ferr_nx = ferr_q | ~rx_s;
          end
        end else begin
          clkd_nx = clkd + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign push = frame_done && !frame_bad && !perr_q;

  // Handshake: a word transfers on a rising clk edge where m_valid && m_ready;
  // m_data holds the head word and stays stable while m_valid is high and not popped.
  logic [BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count;
  logic            full, pop, push_ok;

  assign full       = (count == NW'(FIFO_DEPTH));
  assign m_valid    = (count != '0);
  assign pop        = m_valid && m_ready;
  assign push_ok    = push && (!full || pop);
  assign m_data     = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_done && frame_bad;
      overrun   <= push && full && !pop;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= frame_done && !frame_bad && perr_q;
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (DIV = 434); frames are driven on falling edges.
module tb_uart_rx_fifo;

  localparam int DIV = 434;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Negedges from the start-bit edge to the one just before the final stop-sample clock edge.
  localparam int PUSH_OFS = 2 + 217 + DIV * (FRAME_BITS - 1);

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip;
  int         pe_cnt;
`endif

  int checks;
  int failures;
  int fe_cnt;
  int ov_cnt;
  logic [7:0] exp_q[$];

  uart_rx_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1)   ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) pe_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic b, input int n);
    rx = b;
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_len);
    bit_time(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_time(d[i], 1);
`ifdef UART_RX_PARITY_EN
    bit_time(^d ^ par_flip, 1);
`endif
    bit_time(stop_lvl, stop_len);
    rx = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, {15'd0, m_valid}, 16'd1);
    check({tag, "_data"}, {8'd0, m_data}, {8'd0, e});
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    fe_cnt   = 0;
    ov_cnt   = 0;
`ifdef UART_RX_PARITY_EN
    pe_cnt   = 0;
    par_flip = 1'b0;
`endif
    rx      = 1'b1;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", {15'd0, m_valid}, 16'd0);
    check("rst_data", {8'd0, m_data}, 16'd0);
    check("rst_count", {13'd0, fifo_count}, 16'd0);
    check("rst_ferr", {15'd0, frame_err}, 16'd0);
    check("rst_ovr", {15'd0, overrun}, 16'd0);

    // Single good frame, consumer not ready
    send_frame(8'hA5, 1'b1, 1);
    idle(4);
    check("a5_valid", {15'd0, m_valid}, 16'd1);
    check("a5_data", {8'd0, m_data}, 16'h00A5);
    check("a5_count", {13'd0, fifo_count}, 16'd1);
    check("a5_ferr_cnt", 16'(fe_cnt), 16'd0);
    check("a5_ovr_cnt", 16'(ov_cnt), 16'd0);

    // Reset in the middle of a frame flushes the FIFO and raises no flags
    rx = 1'b0;
    repeat (1000) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_count", {13'd0, fifo_count}, 16'd0);
    check("midrst_valid", {15'd0, m_valid}, 16'd0);
    rx    = 1'b1;
    rst_n = 1'b1;
    idle(1000);
    check("midrst_count_after", {13'd0, fifo_count}, 16'd0);
    check("midrst_ferr_cnt", 16'(fe_cnt), 16'd0);

    // 100-clock low glitch is rejected at the start-bit sample
    rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(800);
    check("glitch_valid", {15'd0, m_valid}, 16'd0);
    check("glitch_count", {13'd0, fifo_count}, 16'd0);
    check("glitch_ferr_cnt", 16'(fe_cnt), 16'd0);
    check("glitch_ovr_cnt", 16'(ov_cnt), 16'd0);

    // Stop bit held low for two bit times: exactly one frame_err, word discarded
    send_frame(8'h3C, 1'b0, 2);
    idle(50);
    check("brk_ferr_cnt", 16'(fe_cnt), 16'd1);
    check("brk_count", {13'd0, fifo_count}, 16'd0);
    send_frame(8'h81, 1'b1, 1);
    exp_q.push_back(8'h81);
    idle(4);
    check("brk_next_count", {13'd0, fifo_count}, 16'd1);
    check("brk_next_ferr_cnt", 16'(fe_cnt), 16'd1);
    pop_check("brk_next_pop");

    // Five back-to-back frames into a four-entry FIFO: fifth overruns
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1);
      if (i <= 4) exp_q.push_back(8'(i));
    end
    idle(4);
    check("ovr_count", {13'd0, fifo_count}, 16'd4);
    check("ovr_ovr_cnt", 16'(ov_cnt), 16'd1);
    check("ovr_ferr_cnt", 16'(fe_cnt), 16'd1);
    for (int i = 0; i < 4; i++) pop_check("ovr_pop");
    check("ovr_drained_valid", {15'd0, m_valid}, 16'd0);

    // Full FIFO with a pop in the exact push cycle: no overrun, count stays 4
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h11 + 8'(i), 1'b1, 1);
      exp_q.push_back(8'h11 + 8'(i));
    end
    idle(4);
    check("same_full_count", {13'd0, fifo_count}, 16'd4);
    fork
      send_frame(8'h66, 1'b1, 1);
      begin
        repeat (PUSH_OFS) @(negedge clk);
        check("same_head", {8'd0, m_data}, {8'd0, exp_q.pop_front()});
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
      end
    join
    exp_q.push_back(8'h66);
    idle(4);
    check("same_ovr_cnt", 16'(ov_cnt), 16'd1);
    check("same_count", {13'd0, fifo_count}, 16'd4);
    for (int i = 0; i < 4; i++) pop_check("same_pop");
    check("same_drained_valid", {15'd0, m_valid}, 16'd0);

`ifdef UART_RX_PARITY_EN
    // 0x07 under even parity needs parity bit 1
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1);
    par_flip = 1'b0;
    idle(4);
    check("par_bad_pe_cnt", 16'(pe_cnt), 16'd1);
    check("par_bad_count", {13'd0, fifo_count}, 16'd0);
    check("par_bad_ferr_cnt", 16'(fe_cnt), 16'd1);
    send_frame(8'h07, 1'b1, 1);
    exp_q.push_back(8'h07);
    idle(4);
    check("par_good_pe_cnt", 16'(pe_cnt), 16'd1);
    pop_check("par_good_pop");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
